// File: rtl/lib_arbiter_pkg.sv
// lib_arbiter_pkg: shared types and grant-encoding helper for the row arbiter and its requesters.
package lib_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SERVE} req_state_t;

    typedef struct packed {
        logic [4:0] idx;
        logic       one;
    } onehot_t;

    // idx is the highest set bit; one is true only for exactly one bit set
    function automatic onehot_t onehot_idx(input logic [31:0] v);
        onehot_t r;
        r.idx = '0;
        for (int i = 0; i < 32; i++) if (v[i]) r.idx = 5'(i);
        r.one = (v != '0) && ((v & (v - 32'd1)) == '0);
        return r;
    endfunction

endpackage

// File: rtl/row_event_bank.sv
// row_event_bank: capture/serve double bank of pixel events with a saturating merged-event counter.
module row_event_bank #(
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ROWS-1:0][COLS-1:0]  events,
    input  logic                       swap,
    input  logic [ROWS-1:0]            clr,
    output logic                       pending,
    output logic [ROWS-1:0][COLS-1:0]  serve,
    output logic [DROP_W-1:0]          drop_cnt
);

    logic [ROWS-1:0][COLS-1:0] cap, merged, keep;
    logic [DROP_W:0]           sum;

    always_comb begin
        merged  = swap ? '0 : cap & events;
        sum     = {1'b0, drop_cnt} + (DROP_W+1)'($countones(merged));
        pending = |cap;
        keep    = '0;
        for (int r = 0; r < ROWS; r++) keep[r] = {COLS{~clr[r]}};
    end

    // on a swap the old capture moves to serve, so nothing is merged that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap      <= '0;
            serve    <= '0;
            drop_cnt <= '0;
        end else begin
            cap      <= swap ? events : cap | events;
            serve    <= swap ? cap : serve & keep;
            drop_cnt <= sum[DROP_W] ? '1 : sum[DROP_W-1:0];
        end
    end

endmodule

// File: rtl/row_event_requester.sv
// row_event_requester: requesting end of the row request/grant protocol; serves snapshotted
// pixel events one row per accepted grant.
module row_event_requester
    import lib_arbiter_pkg::*;
#(
    parameter int Lvl_ROWS    = 2,
    parameter int Lvl_COLS    = 2,
    parameter int Lvl_ROW_ADD = 1,
    parameter int DROP_W      = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         enable_i,
    input  logic [Lvl_ROWS*Lvl_COLS-1:0] event_i,
    input  logic [Lvl_ROWS-1:0]          gnt_i,
    output logic [Lvl_ROWS-1:0]          req_o,
    output logic                         arb_en_o,
    output logic                         refresh_o,
    output logic [Lvl_COLS-1:0]          row_data_o,
    output logic [Lvl_ROW_ADD-1:0]       row_add_o,
    output logic                         row_valid_o,
    output logic [DROP_W-1:0]            drop_cnt_o,
    output logic                         proto_err_o
);

    req_state_t                        state;
    onehot_t                           oh;
    logic [Lvl_ROW_ADD-1:0]            k;
    logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] serve;
    logic [Lvl_ROWS-1:0]               clr;
    logic                              pending, swap, acc, hit, arb_en_q;

    row_event_bank #(.ROWS(Lvl_ROWS), .COLS(Lvl_COLS), .DROP_W(DROP_W)) u_bank (
        .clk      (clk_i),
        .rst_n    (reset_i),
        .events   (event_i),
        .swap     (swap),
        .clr      (clr),
        .pending  (pending),
        .serve    (serve),
        .drop_cnt (drop_cnt_o)
    );

    // a grant is trusted only when the arbiter saw enable on the previous edge
    always_comb begin
        oh        = onehot_idx(32'(gnt_i));
        k         = Lvl_ROW_ADD'(oh.idx);
        arb_en_o  = (state == SERVE) && enable_i;
        refresh_o = state == LOAD;
        swap      = (state == IDLE) && enable_i && pending;
        acc       = arb_en_o && arb_en_q;
        hit       = acc && oh.one && (serve[k] != '0);
        clr       = hit ? Lvl_ROWS'(1) << k : '0;
        req_o     = '0;
        for (int r = 0; r < Lvl_ROWS; r++) req_o[r] = |serve[r];
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            arb_en_q    <= 1'b0;
            row_valid_o <= 1'b0;
            row_data_o  <= '0;
            row_add_o   <= '0;
            proto_err_o <= 1'b0;
        end else begin
            state       <= swap ? LOAD :
                           state == LOAD ? SERVE :
                           (hit && (req_o & ~clr) == '0) ? IDLE : state;
            arb_en_q    <= arb_en_o;
            row_valid_o <= hit;
            row_data_o  <= hit ? serve[k] : row_data_o;
            row_add_o   <= hit ? k : row_add_o;
            proto_err_o <= proto_err_o | (acc && gnt_i != '0 && !oh.one);
        end
    end

endmodule

// File: tb/tb_row_event_requester.sv
// tb_row_event_requester: directed checks of the row requester with hand-computed expectations.
module tb_row_event_requester;

    logic       clk_i = 1'b0;
    logic       reset_i, enable_i;
    logic [3:0] event_i;
    logic [1:0] gnt_i;
    logic [1:0] req_o, row_data_o;
    logic       arb_en_o, refresh_o, row_valid_o, proto_err_o;
    logic [0:0] row_add_o;
    logic [7:0] drop_cnt_o;

    logic [3:0] ev2;
    logic [1:0] req2, data2;
    logic       arb2, ref2, val2, perr2;
    logic [0:0] add2;
    logic [1:0] drop2;

    int total = 0;
    int bad   = 0;

    row_event_requester dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .event_i(event_i),
        .gnt_i(gnt_i), .req_o(req_o), .arb_en_o(arb_en_o), .refresh_o(refresh_o),
        .row_data_o(row_data_o), .row_add_o(row_add_o), .row_valid_o(row_valid_o),
        .drop_cnt_o(drop_cnt_o), .proto_err_o(proto_err_o)
    );

    row_event_requester #(.DROP_W(2)) dut2 (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(1'b0), .event_i(ev2),
        .gnt_i(2'b00), .req_o(req2), .arb_en_o(arb2), .refresh_o(ref2),
        .row_data_o(data2), .row_add_o(add2), .row_valid_o(val2),
        .drop_cnt_o(drop2), .proto_err_o(perr2)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic ctl(input string tag, input logic [1:0] req, input logic arb,
                       input logic rf, input logic val);
        chk({tag, ".req"}, 32'(req_o), 32'(req));
        chk({tag, ".arb_en"}, 32'(arb_en_o), 32'(arb));
        chk({tag, ".refresh"}, 32'(refresh_o), 32'(rf));
        chk({tag, ".valid"}, 32'(row_valid_o), 32'(val));
    endtask

    task automatic row(input string tag, input logic [1:0] data, input logic add);
        chk({tag, ".data"}, 32'(row_data_o), 32'(data));
        chk({tag, ".add"}, 32'(row_add_o), 32'(add));
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i = 1'b0; enable_i = 1'b0; event_i = 4'hF; gnt_i = 2'b00; ev2 = 4'h0;
        tick; tick;
        ctl("rst", 2'b00, 0, 0, 0);
        row("rst", 2'b00, 0);
        chk("rst.drop", 32'(drop_cnt_o), 0);
        chk("rst.perr", 32'(proto_err_o), 0);
        // release with all events held: first cycle only captures
        reset_i = 1'b1;
        tick;
        chk("rel.drop", 32'(drop_cnt_o), 0);
        chk("rel.req", 32'(req_o), 0);
        event_i = 4'h0;
        tick;
        chk("rel.drop2", 32'(drop_cnt_o), 0);
        enable_i = 1'b1;
        tick; ctl("f.load", 2'b11, 0, 1, 0);
        tick; ctl("f.serve", 2'b11, 1, 0, 0);
        gnt_i = 2'b01;
        tick; ctl("f.stale", 2'b11, 1, 0, 0);
        tick; ctl("f.g0", 2'b10, 1, 0, 1); row("f.g0", 2'b11, 0);
        gnt_i = 2'b10;
        tick; ctl("f.g1", 2'b00, 0, 0, 1); row("f.g1", 2'b11, 1);
        gnt_i = 2'b00;

        // single event row1 col0
        event_i = 4'b0100;
        tick; ctl("t2.cap", 2'b00, 0, 0, 0);
        event_i = 4'h0;
        tick; ctl("t2.load", 2'b10, 0, 1, 0);
        tick; ctl("t2.serve", 2'b10, 1, 0, 0);
        gnt_i = 2'b10;
        tick; ctl("t2.stale", 2'b10, 1, 0, 0);
        tick; ctl("t2.grant", 2'b00, 0, 0, 1); row("t2.grant", 2'b01, 1);
        gnt_i = 2'b00;

        // two rows, with a re-grant of an already served row
        event_i = 4'b1001;
        tick; event_i = 4'h0;
        tick; ctl("t3.load", 2'b11, 0, 1, 0);
        tick; ctl("t3.serve", 2'b11, 1, 0, 0);
        gnt_i = 2'b01;
        tick; ctl("t3.stale", 2'b11, 1, 0, 0);
        tick; ctl("t3.g0", 2'b10, 1, 0, 1); row("t3.g0", 2'b01, 0);
        tick; ctl("t3.regrant", 2'b10, 1, 0, 0);
        gnt_i = 2'b10;
        tick; ctl("t3.g1", 2'b00, 0, 0, 1); row("t3.g1", 2'b10, 1);
        tick; ctl("t3.after", 2'b00, 0, 0, 0);
        gnt_i = 2'b00;

        // event arriving on the swap edge goes to the new capture
        event_i = 4'b0010;
        tick; event_i = 4'b0001;
        tick; ctl("t4.load", 2'b01, 0, 1, 0);
        event_i = 4'h0;
        tick; ctl("t4.serve", 2'b01, 1, 0, 0);
        gnt_i = 2'b01;
        tick; ctl("t4.stale", 2'b01, 1, 0, 0);
        tick; ctl("t4.g0", 2'b00, 0, 0, 1); row("t4.g0", 2'b10, 0);
        gnt_i = 2'b00;
        tick; ctl("t4.load2", 2'b01, 0, 1, 0);
        tick; ctl("t4.serve2", 2'b01, 1, 0, 0);
        gnt_i = 2'b01;
        tick; tick; ctl("t4.g0b", 2'b00, 0, 0, 1); row("t4.g0b", 2'b01, 0);
        chk("t4.drop", 32'(drop_cnt_o), 0);
        gnt_i = 2'b00;

        // four events on bit 0 while disabled, then a multi-bit grant
        enable_i = 1'b0; event_i = 4'b0001;
        repeat (4) tick;
        event_i = 4'h0;
        chk("t5.drop", 32'(drop_cnt_o), 3);
        ctl("t5.idle", 2'b00, 0, 0, 0);
        enable_i = 1'b1;
        tick; ctl("t5.load", 2'b01, 0, 1, 0);
        tick; gnt_i = 2'b11;
        tick; chk("t5.stale_perr", 32'(proto_err_o), 0);
        tick; ctl("t5.multi", 2'b01, 1, 0, 0);
        chk("t5.perr", 32'(proto_err_o), 1);
        gnt_i = 2'b01;
        tick; ctl("t5.g0", 2'b00, 0, 0, 1); row("t5.g0", 2'b01, 0);
        chk("t5.perr_hold", 32'(proto_err_o), 1);
        gnt_i = 2'b00;

        // enable dropped mid-serve for three cycles
        event_i = 4'b1010;
        tick; event_i = 4'h0;
        tick; ctl("t6.load", 2'b11, 0, 1, 0);
        tick; gnt_i = 2'b01;
        tick; tick; ctl("t6.g0", 2'b10, 1, 0, 1); row("t6.g0", 2'b10, 0);
        enable_i = 1'b0; gnt_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick; ctl("t6.hold", 2'b10, 0, 0, 0); row("t6.hold", 2'b10, 0);
        end
        enable_i = 1'b1;
        tick; ctl("t6.resume", 2'b10, 1, 0, 0);
        tick; ctl("t6.g1", 2'b00, 0, 0, 1); row("t6.g1", 2'b10, 1);
        chk("t6.perr", 32'(proto_err_o), 1);
        chk("t6.drop", 32'(drop_cnt_o), 3);
        gnt_i = 2'b00;

        // asynchronous reset in the middle of serving
        event_i = 4'b0011;
        tick; event_i = 4'h0;
        tick; tick; ctl("t7.serve", 2'b01, 1, 0, 0);
        reset_i = 1'b0;
        #1;
        ctl("t7.arst", 2'b00, 0, 0, 0);
        chk("t7.perr", 32'(proto_err_o), 0);
        chk("t7.drop", 32'(drop_cnt_o), 0);
        tick; reset_i = 1'b1;
        tick; tick; ctl("t7.post", 2'b00, 0, 0, 0);

        // narrow counter saturates
        ev2 = 4'b0001;
        repeat (4) tick;
        chk("t8.drop4", 32'(drop2), 3);
        tick;
        chk("t8.drop5", 32'(drop2), 3);
        ev2 = 4'h0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
